// File: rtl/hdc_if.sv
// rtl/hdc_if.sv - Request/result bundle for hdc_main; DIST_OUT_EN adds the distance outputs.
interface hdc_if #(
    parameter int MAX_LENGTH = 160,
    parameter int CHAR_W     = 7,
    parameter int DIM        = 64,
    parameter int LEN_W      = 8
);
    logic                         start;
    logic [MAX_LENGTH*CHAR_W-1:0] data;
    logic [LEN_W-1:0]             length;
    logic [DIM-1:0]               ham_hv;
    logic [DIM-1:0]               spam_hv;
    logic                         busy;
    logic                         valid;
    logic                         label;
`ifdef DIST_OUT_EN
    logic [$clog2(DIM+1)-1:0]     dist_ham;
    logic [$clog2(DIM+1)-1:0]     dist_spam;
`endif

    modport master (
        output start, data, length, ham_hv, spam_hv,
        input  busy, valid, label
`ifdef DIST_OUT_EN
        , input dist_ham, dist_spam
`endif
    );

    modport slave (
        input  start, data, length, ham_hv, spam_hv,
        output busy, valid, label
`ifdef DIST_OUT_EN
        , output dist_ham, dist_spam
`endif
    );
endinterface

// File: rtl/hdc_main.sv
// rtl/hdc_main.sv - HDC trigram-bundling ham/spam classifier; DIST_OUT_EN exposes Hamming distances.
module hdc_main #(
    parameter int             MAX_LENGTH = 160,
    parameter int             CHAR_W     = 7,
    parameter int             DIM        = 64,
    parameter logic [DIM-1:0] SEED       = 64'hA5C3_96E1_0F4B_D287,
    parameter int             LEN_W      = 8
) (
    input  logic clk,
    input  logic reset,
    hdc_if.slave bus
);
    localparam int DW = $clog2(DIM + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENCODE  = 2'd1;
    localparam logic [1:0] S_THRESH  = 2'd2;
    localparam logic [1:0] S_COMPARE = 2'd3;

    function automatic logic [DIM-1:0] rotl(input logic [DIM-1:0] x, input int unsigned n);
        logic [2*DIM-1:0] t;
        t = {x, x} << n;
        return t[2*DIM-1:DIM];
    endfunction

    function automatic logic [DIM-1:0] item_hv(input logic [CHAR_W-1:0] c);
        return rotl(SEED, int'(c[5:0])) ^ {DIM{c[6]}};
    endfunction

    logic [1:0]                   state;
    logic [MAX_LENGTH*CHAR_W-1:0] data_r;
    logic [LEN_W-1:0]             len_r;
    logic [LEN_W-1:0]             idx;
    logic [DIM-1:0]               ham_r;
    logic [DIM-1:0]               spam_r;
    logic [DIM-1:0]               win1;
    logic [DIM-1:0]               win2;
    logic [DIM-1:0]               query;
    logic [LEN_W-1:0]             cnt [DIM];
    logic                         pend;
    logic                         pend_label;
    logic                         busy_r;
    logic                         valid_r;
    logic                         label_r;
`ifdef DIST_OUT_EN
    logic [DW-1:0]                pend_dh;
    logic [DW-1:0]                pend_ds;
    logic [DW-1:0]                dist_ham_r;
    logic [DW-1:0]                dist_spam_r;
`endif

    logic [LEN_W-1:0]  len_clamp;
    logic [CHAR_W-1:0] cur_char;
    logic [DIM-1:0]    cur_hv;
    logic [DIM-1:0]    gram;
    logic [LEN_W-1:0]  n_tri;
    logic [DIM-1:0]    query_next;
    logic [DW-1:0]     dh;
    logic [DW-1:0]     ds;

    assign len_clamp = (int'(bus.length) > MAX_LENGTH) ? LEN_W'(MAX_LENGTH) : bus.length;
    assign cur_char  = data_r[CHAR_W*int'(idx) +: CHAR_W];
    assign cur_hv    = item_hv(cur_char);
    assign gram      = rotl(win2, 2) ^ rotl(win1, 1) ^ cur_hv;
    assign n_tri     = (len_r > LEN_W'(2)) ? len_r - LEN_W'(2) : '0;

    // Strict majority: doubling the count avoids a divide and makes ties resolve to 0.
    always_comb begin
        query_next = '0;
        for (int j = 0; j < DIM; j++) begin
            query_next[j] = {cnt[j], 1'b0} > {1'b0, n_tri};
        end
    end

    always_comb begin
        dh = '0;
        ds = '0;
        for (int j = 0; j < DIM; j++) begin
            dh = dh + DW'(query[j] ^ ham_r[j]);
            ds = ds + DW'(query[j] ^ spam_r[j]);
        end
    end

    // COMPARE registers the decision; the following IDLE cycle publishes it, which keeps
    // the popcount off the output path and makes start acceptable during the valid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            len_r      <= '0;
            win1       <= '0;
            win2       <= '0;
            query      <= '0;
            pend       <= 1'b0;
            pend_label <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            label_r    <= 1'b0;
            for (int j = 0; j < DIM; j++) cnt[j] <= '0;
`ifdef DIST_OUT_EN
            pend_dh     <= '0;
            pend_ds     <= '0;
            dist_ham_r  <= '0;
            dist_spam_r <= '0;
`endif
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        pend    <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        label_r <= pend_label;
`ifdef DIST_OUT_EN
                        dist_ham_r  <= pend_dh;
                        dist_spam_r <= pend_ds;
`endif
                    end else if (bus.start) begin
                        data_r <= bus.data;
                        len_r  <= len_clamp;
                        ham_r  <= bus.ham_hv;
                        spam_r <= bus.spam_hv;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        for (int j = 0; j < DIM; j++) cnt[j] <= '0;
                        state  <= (len_clamp == '0) ? S_THRESH : S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    if (idx >= LEN_W'(2)) begin
                        for (int j = 0; j < DIM; j++) cnt[j] <= cnt[j] + LEN_W'(gram[j]);
                    end
                    win2 <= win1;
                    win1 <= cur_hv;
                    idx  <= idx + LEN_W'(1);
                    if (idx == len_r - LEN_W'(1)) state <= S_THRESH;
                end
                S_THRESH: begin
                    query <= query_next;
                    state <= S_COMPARE;
                end
                default: begin
                    pend_label <= (ds < dh);
`ifdef DIST_OUT_EN
                    pend_dh    <= dh;
                    pend_ds    <= ds;
`endif
                    pend       <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.label = label_r;
`ifdef DIST_OUT_EN
    assign bus.dist_ham  = dist_ham_r;
    assign bus.dist_spam = dist_spam_r;
`endif
endmodule

// File: tb/tb_hdc_main.sv
// tb/tb_hdc_main.sv - Directed plus randomized bench for hdc_main against a trigram-bundling model.
module tb_hdc_main;
    localparam logic [63:0] SEED = 64'hA5C3_96E1_0F4B_D287;
    typedef logic [1119:0] text_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hdc_if #(.MAX_LENGTH(160), .CHAR_W(7), .DIM(64), .LEN_W(8)) bus ();

    hdc_main #(.MAX_LENGTH(160), .CHAR_W(7), .DIM(64), .SEED(SEED), .LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        int m = n % 64;
        if (m == 0) return x;
        return (x << m) | (x >> (64 - m));
    endfunction

    function automatic logic [63:0] item_hv(input logic [6:0] c);
        logic [63:0] r = rotl64(SEED, int'(c[5:0]));
        return c[6] ? ~r : r;
    endfunction

    function automatic logic [63:0] model_query(input text_t d, input int len);
        int          cnt [64];
        int          n;
        logic [63:0] g;
        logic [63:0] q;
        n = (len > 2) ? len - 2 : 0;
        for (int j = 0; j < 64; j++) cnt[j] = 0;
        for (int i = 2; i < len; i++) begin
            g = rotl64(item_hv(d[7*(i-2) +: 7]), 2) ^ rotl64(item_hv(d[7*(i-1) +: 7]), 1)
                ^ item_hv(d[7*i +: 7]);
            for (int j = 0; j < 64; j++) if (g[j]) cnt[j]++;
        end
        for (int j = 0; j < 64; j++) q[j] = (2 * cnt[j] > n);
        return q;
    endfunction

    function automatic text_t repeat_char(input int n, input logic [6:0] c);
        text_t t = '0;
        for (int i = 0; i < n; i++) t[7*i +: 7] = c;
        return t;
    endfunction

    function automatic text_t random_text();
        text_t t;
        for (int i = 0; i < 160; i++) t[7*i +: 7] = 7'($urandom_range(0, 127));
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit wait_neg, input int len, input text_t d,
                          input logic [63:0] h, input logic [63:0] s);
        if (wait_neg) @(negedge clk);
        bus.start   = 1'b1;
        bus.data    = d;
        bus.length  = 8'(len);
        bus.ham_hv  = h;
        bus.spam_hv = s;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data    = random_text();
        bus.length  = 8'($urandom);
        bus.ham_hv  = ~h;
        bus.spam_hv = ~s;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("valid_low_after_accept", 64'(bus.valid), 64'd0);
    endtask

    task automatic await_result(input string tag, input int k0, input int exp_lat,
                                input int exp_dh, input int exp_ds);
        int k = k0;
        bit seen = 1'b0;
        while (!seen && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            seen = bus.valid;
        end
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "_label"}, 64'(bus.label), 64'(exp_ds < exp_dh));
        chk({tag, "_busy_at_valid"}, 64'(bus.busy), 64'd0);
`ifdef DIST_OUT_EN
        chk({tag, "_dist_ham"}, 64'(bus.dist_ham), 64'(exp_dh));
        chk({tag, "_dist_spam"}, 64'(bus.dist_spam), 64'(exp_ds));
`endif
    endtask

    initial begin
        logic [63:0] h, q, hv_a, hv_b;
        text_t       d, d2;
        int          len, vcount;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data    = '0;
        bus.length  = '0;
        bus.ham_hv  = '0;
        bus.spam_hv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_valid", 64'(bus.valid), 64'd0);
        chk("reset_label", 64'(bus.label), 64'd0);
        reset = 1'b0;

        launch(1'b1, 0, random_text(), '0, '0);
        await_result("len0", 0, 3, 0, 0);

        h = item_hv(7'h61);
        q = rotl64(h, 2) ^ rotl64(h, 1) ^ h;
        d = repeat_char(3, 7'h61);
        launch(1'b1, 3, d, ~q, q);
        await_result("aaa_spam", 0, 6, 64, 0);
        launch(1'b1, 3, d, q, ~q);
        await_result("aaa_ham", 0, 6, 0, 64);
        launch(1'b1, 3, d, q, q);
        await_result("aaa_tie", 0, 6, 0, 0);
        launch(1'b1, 5, repeat_char(5, 7'h61), ~q, q);
        await_result("aaaaa_spam", 0, 8, 64, 0);

        launch(1'b1, 20, random_text(), $urandom, $urandom);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_valid", 64'(bus.valid), 64'd0);
        chk("midreset_label", 64'(bus.label), 64'd0);
        reset  = 1'b0;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid) vcount++;
        end
        chk("midreset_no_valid", 64'(vcount), 64'd0);

        d = random_text();
        q = model_query(d, 160);
        hv_a = {$urandom, $urandom};
        hv_b = q ^ 64'(1 << $urandom_range(0, 31));
        launch(1'b1, 200, d, hv_a, hv_b);
        await_result("clamp200", 0, 163, $countones(q ^ hv_a), $countones(q ^ hv_b));

        for (int r = 0; r < 10; r++) begin
            len  = $urandom_range(0, 30);
            d    = random_text();
            q    = model_query(d, len);
            hv_a = {$urandom, $urandom};
            hv_b = (r % 2 == 0) ? (q ^ {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom})
                                : {$urandom, $urandom};
            if (r % 4 == 1) begin
                hv_a = hv_b;
                hv_b = {$urandom, $urandom};
            end
            launch(1'b1, len, d, hv_a, hv_b);
            await_result("random", 0, len + 3, $countones(q ^ hv_a), $countones(q ^ hv_b));
        end

        d    = random_text();
        q    = model_query(d, 12);
        hv_a = {$urandom, $urandom};
        hv_b = q ^ 64'h1;
        launch(1'b1, 12, d, hv_a, hv_b);
        bus.start   = 1'b1;
        bus.data    = random_text();
        bus.length  = 8'd4;
        bus.ham_hv  = hv_b;
        bus.spam_hv = hv_a;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        await_result("start_while_busy", 1, 15, $countones(q ^ hv_a), $countones(q ^ hv_b));

        d    = random_text();
        q    = model_query(d, 7);
        hv_a = q;
        hv_b = ~q;
        launch(1'b1, 7, d, hv_a, hv_b);
        await_result("b2b_first", 0, 10, 0, 64);
        d2   = random_text();
        q    = model_query(d2, 9);
        launch(1'b0, 9, d2, ~q, q ^ 64'h3);
        await_result("b2b_second", 0, 12, 64, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdc_main.md
Name: hdc_main

Overview:
- Hyperdimensional-computing (HDC) text classifier for short messages; the top-level compute block of the SMS ham/spam demonstrator.
- Takes a packed string of 7-bit ASCII characters, its length, and two class hypervectors (HAM, SPAM).
- Encodes character trigrams into a query hypervector by bundling, then labels the message by nearest Hamming distance.

Parameters:
- MAX_LENGTH, 160, maximum characters per message.
- CHAR_W, 7, bits per character.
- DIM, 64, hypervector width in bits.
- SEED, 64'hA5C3_96E1_0F4B_D287, base item-memory vector (DIM bits).
- LEN_W, 8, width of the length input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- data  in  MAX_LENGTH*CHAR_W  packed text; char i = data[CHAR_W*i+CHAR_W-1 : CHAR_W*i].
- length  in  LEN_W  number of valid characters.
- ham_hv  in  DIM  HAM class hypervector.
- spam_hv  in  DIM  SPAM class hypervector.
- busy  out  1  high from the cycle after start is accepted until valid.
- valid  out  1  one-cycle pulse; label is valid.
- label  out  1  0 = ham, 1 = spam; held until the next result.

Behaviour:
- One clock domain. Reset is synchronous and active-high: busy=0, valid=0, label=0, FSM=IDLE, counters cleared. Reset mid-operation aborts the job and produces no valid.
- On start in IDLE, latch data, length (clamped to MAX_LENGTH), ham_hv and spam_hv. Later input changes are ignored. start while busy is ignored.
- Item memory: HV(c) = ROTL(SEED, c[5:0]), XORed with all-ones when c[6]=1. ROTL(x,n) is a left rotate by n over DIM bits.
- FSM: IDLE -> ENCODE (L cycles; skipped if L=0) -> THRESH (1) -> COMPARE (1) -> IDLE, where L is the clamped length.
- ENCODE: one character per cycle, index 0 upward. A 2-deep window holds HV(c[i-1]) and HV(c[i-2]).
  - For i >= 2, G = ROTL(HV(c[i-2]),2) ^ ROTL(HV(c[i-1]),1) ^ HV(c[i]).
  - Each of DIM per-bit counters (width LEN_W) increments where G bit = 1.
  - Trigram count N = max(L-2, 0).
- THRESH: query bit j = 1 iff 2*count[j] > N (strict majority; a tie gives 0). When N = 0, the query is all zeros.
- COMPARE: dh = popcount(query ^ ham_hv), ds = popcount(query ^ spam_hv). label = 1 iff ds < dh; a tie gives ham (0).
- valid rises exactly L+3 rising edges after the edge that accepted start, for one cycle. busy falls in the same cycle valid rises.
- label updates only on valid.
- A new start is accepted in the cycle valid is high (back-to-back operation).

Optional Feature:
- Macro DIST_OUT_EN.
- Defined: adds outputs dist_ham and dist_spam, each $clog2(DIM+1) bits. They carry dh and ds, update together with label, and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles mid-ENCODE -> busy=0, valid=0, label=0; no valid pulse follows.
- L=0, start -> valid exactly 3 edges later, label=0 (query zero; ham_hv=spam_hv=0 gives a tie, so ham).
- L=3, text "aaa", H=HV(7'h61), Q=ROTL(H,2)^ROTL(H,1)^H; spam_hv=Q, ham_hv=~Q -> valid after 6 edges, label=1 (dist_spam=0, dist_ham=64).
- Same text with ham_hv=Q, spam_hv=~Q -> label=0. With ham_hv=spam_hv=Q -> tie, label=0.
- L=5, text "aaaaa" (3 identical trigrams, majority = Q), spam_hv=Q, ham_hv=~Q -> label=1. length=200 -> clamped to 160; valid after 163 edges.
- start pulsed again during busy with different data -> ignored, result matches first job. start during the valid cycle -> second job accepted.
